// File: rtl/regfile_write_decoder.sv
// Write side of the 32-entry integer register file: one-hot write decode, storage,
// per-register written scoreboard, saturating effective-write counter and debug readback.
module regfile_write_decoder #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [4:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [4:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data,
  output logic [31:0]      written,
  output logic [CNT_W-1:0] wr_count,
  output logic [31:0]      dec_onehot
);

  localparam logic [4:0] XZR = 5'd31;

  // Entry 31 is XZR: the decoder never selects it, so it is held at zero from reset.
  function automatic logic [31:0] decode(input logic en, input logic [4:0] addr);
    logic [31:0] v;
    v = 32'h0000_0000;
    if (en && (addr != XZR)) begin
      v[addr] = 1'b1;
    end else begin
      v = 32'h0000_0000;
    end
    return v;
  endfunction

  logic [WIDTH-1:0] regs_r [32];
  logic [31:0]      written_r;
  logic [CNT_W-1:0] count_r;
  logic [31:0]      dec_s;
  logic [WIDTH-1:0] dbg_s;

  // Write-enable decode for the current cycle.
  always_comb begin
    dec_s = decode(wr_en, wr_addr);
  end

  // Register storage; a nonzero decode implies wr_addr is not XZR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 32; k++) begin
        regs_r[k] <= {WIDTH{1'b0}};
      end
    end else if (|dec_s) begin
      regs_r[wr_addr] <= wr_data;
    end
  end

  // Sticky per-register written flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      written_r <= 32'h0000_0000;
    end else begin
      written_r <= written_r | dec_s;
    end
  end

  // Effective-write counter, saturating at all ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if ((|dec_s) && (count_r != {CNT_W{1'b1}})) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Debug readback without write bypass; XZR reads as zero.
  always_comb begin
    dbg_s = {WIDTH{1'b0}};
    if (dbg_sel == XZR) begin
      dbg_s = {WIDTH{1'b0}};
    end else begin
      dbg_s = regs_r[dbg_sel];
    end
  end

  assign dbg_data   = dbg_s;
  assign written    = written_r;
  assign wr_count   = count_r;
  assign dec_onehot = dec_s;

endmodule

// File: tb/tb_regfile_write_decoder.sv
// Self-checking bench for regfile_write_decoder: scoreboard of expected post-edge state,
// plus a second instance with a 3-bit counter for saturation.
module tb_regfile_write_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = 5'd0;
  logic [63:0] wr_data = 64'd0;
  logic [4:0]  dbg_sel = 5'd0;
  logic [63:0] dbg_data, dbg_data3;
  logic [31:0] written, written3, dec_onehot, dec_onehot3;
  logic [15:0] wr_count;
  logic [2:0]  wr_count3;

  int n_tests = 0;
  int n_fail = 0;

  logic [63:0] mreg [32];
  logic [31:0] mwritten;
  int          mcount, mcount3;

  typedef struct {
    logic [4:0]  sel;
    logic [63:0] data;
    logic [31:0] wr;
    logic [15:0] cnt;
    logic [2:0]  cnt3;
  } exp_t;
  exp_t sb[$];

  regfile_write_decoder #(.WIDTH(64), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .written(written), .wr_count(wr_count),
    .dec_onehot(dec_onehot)
  );

  regfile_write_decoder #(.WIDTH(64), .CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data3), .written(written3), .wr_count(wr_count3),
    .dec_onehot(dec_onehot3)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    for (int k = 0; k < 32; k++) mreg[k] = 64'd0;
    mwritten = 32'd0;
    mcount = 0;
    mcount3 = 0;
  endtask

  // One cycle: drive, check decode and pre-edge readback, push expectation, check after edge.
  task automatic drive_cycle(input logic en, input logic [4:0] addr, input logic [63:0] data,
                             input logic [4:0] sel);
    logic [31:0] exp_dec;
    logic [63:0] old_val;
    exp_t e;
    @(negedge clk);
    wr_en = en; wr_addr = addr; wr_data = data; dbg_sel = sel;
    exp_dec = 32'd0;
    for (int k = 0; k < 31; k++) if (en && (addr == k[4:0])) exp_dec[k] = 1'b1;
    old_val = mreg[sel];
    #1;
    n_tests++;
    if (dec_onehot !== exp_dec || dec_onehot3 !== exp_dec) begin
      n_fail++;
      $display("FAIL dec_onehot: got %h/%h expected %h", dec_onehot, dec_onehot3, exp_dec);
    end
    n_tests++;
    if (dbg_data !== old_val) begin
      n_fail++;
      $display("FAIL pre_edge_read sel=%0d: got %h expected %h", sel, dbg_data, old_val);
    end
    if (exp_dec != 32'd0) begin
      mreg[addr] = data;
      mwritten[addr] = 1'b1;
      if (mcount < 65535) mcount++;
      if (mcount3 < 7) mcount3++;
    end
    e.sel = sel; e.data = mreg[sel]; e.wr = mwritten;
    e.cnt = mcount[15:0]; e.cnt3 = mcount3[2:0];
    sb.push_back(e);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    e = sb.pop_front();
    dbg_sel = e.sel;
    #1;
    n_tests++;
    if (dbg_data !== e.data || dbg_data3 !== e.data) begin
      n_fail++;
      $display("FAIL post_edge_read sel=%0d: got %h/%h expected %h", e.sel, dbg_data, dbg_data3, e.data);
    end
    n_tests++;
    if (written !== e.wr || written3 !== e.wr) begin
      n_fail++;
      $display("FAIL written: got %h/%h expected %h", written, written3, e.wr);
    end
    n_tests++;
    if (wr_count !== e.cnt || wr_count3 !== e.cnt3) begin
      n_fail++;
      $display("FAIL wr_count: got %0d/%0d expected %0d/%0d", wr_count, wr_count3, e.cnt, e.cnt3);
    end
  endtask

  task automatic check_cleared(input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      dbg_sel = k[4:0];
      #0.1;
      if (dbg_data !== 64'd0 || dbg_data3 !== 64'd0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s regs: %0d registers not zero, expected 0", tag, bad);
    end
    n_tests++;
    if (written !== 32'd0 || written3 !== 32'd0 || wr_count !== 16'd0 || wr_count3 !== 3'd0) begin
      n_fail++;
      $display("FAIL %s state: written=%h count=%0d count3=%0d expected 0", tag, written, wr_count, wr_count3);
    end
  endtask

  // Reset asserted between edges, optionally with a write pending in that cycle.
  task automatic apply_reset(input logic pending);
    @(negedge clk);
    if (pending) begin
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hFFFF_0000_FFFF_0000;
    end else begin
      wr_en = 1'b0;
    end
    #2;
    reset = 1'b1;
    #1;
    check_cleared("reset_immediate");
    @(posedge clk);
    #1;
    check_cleared("reset_held");
    wr_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    #1;
    check_cleared("power_on");
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    drive_cycle(1'b1, 5'd9, 64'h55, 5'd9);
    drive_cycle(1'b1, 5'd20, 64'h77, 5'd20);
    apply_reset(1'b0);
  endtask

  task automatic test_single_write();
    drive_cycle(1'b1, 5'd5, 64'hDEAD_BEEF_0123_4567, 5'd5);
    for (int s = 4; s <= 6; s += 2) begin
      dbg_sel = s[4:0];
      #1;
      n_tests++;
      if (dbg_data !== 64'd0) begin
        n_fail++;
        $display("FAIL neighbour_read sel=%0d: got %h expected 0", s, dbg_data);
      end
    end
    n_tests++;
    if (written !== 32'h0000_0020 || wr_count !== 16'd1) begin
      n_fail++;
      $display("FAIL single_write: written=%h count=%0d expected 00000020/1", written, wr_count);
    end
  endtask

  task automatic test_xzr();
    drive_cycle(1'b1, 5'd31, {64{1'b1}}, 5'd31);
  endtask

  task automatic test_disabled();
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 5'd7, 64'h1234, 5'd7);
  endtask

  task automatic test_fill();
    apply_reset(1'b0);
    for (int k = 0; k < 31; k++) drive_cycle(1'b1, k[4:0], 64'(k + 1), k[4:0]);
    drive_cycle(1'b1, 5'd0, 64'hAA, 5'd0);
    dbg_sel = 5'd30;
    #1;
    n_tests++;
    if (written !== 32'h7FFF_FFFF || wr_count !== 16'd32 || dbg_data !== 64'd31) begin
      n_fail++;
      $display("FAIL fill: written=%h count=%0d r30=%h expected 7fffffff/32/1f", written, wr_count, dbg_data);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++)
      drive_cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  {$urandom, $urandom}, 5'($urandom_range(0, 31)));
  endtask

  task automatic test_saturation();
    apply_reset(1'b0);
    for (int i = 0; i < 10; i++) drive_cycle(1'b1, 5'(i), 64'(i + 100), 5'(i));
    n_tests++;
    if (wr_count3 !== 3'd7 || wr_count !== 16'd10) begin
      n_fail++;
      $display("FAIL saturation: count3=%0d count=%0d expected 7/10", wr_count3, wr_count);
    end
    apply_reset(1'b1);
    drive_cycle(1'b1, 5'd3, 64'h0BAD_F00D, 5'd3);
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single_write();
    test_xzr();
    test_disabled();
    test_fill();
    test_back_to_back();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_decoder.md
Name: regfile_write_decoder

Overview:
Write side of the 32-entry integer register file for the 5-stage pipeline. It is the inverse of the read-side select trees: a 5-to-32 one-hot decoder steers write-back data from the WB stage into exactly one of 32 storage registers. It also keeps a per-register "written" scoreboard and an effective-write counter. A single combinational debug readback port is included so verification can observe storage directly.

Parameters:
WIDTH, 64, data width of each register
CNT_W, 16, width of the effective-write counter

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
wr_en  input  1  write-back enable (RegWrite from WB stage)
wr_addr  input  5  destination register index
wr_data  input  WIDTH  write-back data
dbg_sel  input  5  debug readback register index
dbg_data  output  WIDTH  contents of register dbg_sel (combinational)
written  output  32  bit k = 1 once register k has been written since reset
wr_count  output  CNT_W  number of effective writes since reset, saturating
dec_onehot  output  32  combinational one-hot write-enable vector for the current cycle

Behaviour:
- Reset is asynchronous and active-high. On assertion, the following clear immediately, independent of clk, and stay cleared while reset is high: all 32 registers = 0, written = 0, wr_count = 0.
- Reset asserted mid-operation: a write presented in the same cycle is discarded. No partial update occurs.
- First write after deassertion: takes effect on the first rising clk edge at which reset is low.
- Decoder: dec_onehot[k] = wr_en & (wr_addr == k) for k = 0..30. dec_onehot[31] is always 0.
  - At most one bit is ever set.
  - wr_en = 0 gives all zeros.
- Register 31 is XZR:
  - It is never written.
  - It always reads as 0.
  - written[31] is always 0.
- Storage update, at a rising clk edge with reset low:
  - Register k loads wr_data iff dec_onehot[k] = 1. All other registers hold.
  - Write latency is 1 cycle: the new value is visible on dbg_data starting the cycle after the edge.
- Scoreboard: written[k] is set at the same edge as the write to register k. It stays set until reset; repeated writes keep it at 1.
- Counter: wr_count increments by 1 at each edge where dec_onehot has a set bit. Writes to X31 and cycles with wr_en = 0 do not count.
  - It saturates at 2^CNT_W - 1 and never wraps.
- Readback: dbg_data = register[dbg_sel] combinationally, and 0 when dbg_sel = 31.
  - There is no write-to-read bypass. If dbg_sel == wr_addr during a write cycle, dbg_data shows the old value until the edge.
- No X propagation on outputs after reset.
- wr_addr and wr_data are don't-care while wr_en = 0.

Test Plan:
1. Assert reset with registers holding data, between clock edges → dbg_data = 0 for every dbg_sel, written = 0, wr_count = 0 immediately, without a clock edge.
2. wr_en = 1, wr_addr = 5, wr_data = 64'hDEAD_BEEF_0123_4567, one edge →
   - before the edge: dec_onehot = 32'h0000_0020;
   - after the edge: dbg_sel = 5 reads 64'hDEAD_BEEF_0123_4567, dbg_sel = 4 and 6 read 0, written = 32'h0000_0020, wr_count = 1.
3. wr_en = 1, wr_addr = 31, wr_data = all ones → dec_onehot = 0; after the edge dbg_sel = 31 reads 0, written[31] = 0, wr_count unchanged.
4. wr_en = 0, wr_addr = 7, wr_data = 64'h1234 for 3 edges → register 7 stays 0, wr_count unchanged, dec_onehot = 0.
5. Write registers 0..30 with data = index+1, then rewrite register 0 with 64'hAA →
   - written = 32'h7FFF_FFFF;
   - wr_count = 32;
   - register 0 reads 64'hAA, register 30 reads 31;
   - during the rewrite cycle, dbg_sel = 0 reads 1 before the edge.
6. With CNT_W = 3, perform 10 effective writes → wr_count reaches 7 and holds at 7. Then assert reset mid-write → wr_count = 0 and the pending write is lost.
